vend_ctrl: RTL and testbench

Vending-machine transaction controller that sits directly upstream of the LCD display top. It consumes debounced single-cycle key pulses for goods select, coin insert, confirm and cancel. It produces the goods_index / money / point_flag / money_flag bundle that the display top renders, and also issues dispense and change-return pulses to the actuator side. Credit is tracked internally in half-yuan units; money/point_flag are the display split of that credit.

---
 rtl/vend_pkg.sv | 34 +++
 rtl/vend_hold_timer.sv | 33 +++
 rtl/vend_ctrl.sv | 171 +++++++++++++++++
 tb/tb_vend_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared types and constants for the vending transaction controller.
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PAY    = 2'd1,
    VEND   = 2'd2,
    CHANGE = 2'd3
  } state_e;

  localparam logic [1:0] FLAG_NORMAL = 2'b00;
  localparam logic [1:0] FLAG_VEND   = 2'b01;
  localparam logic [1:0] FLAG_SHORT  = 2'b10;
  localparam logic [1:0] FLAG_CHANGE = 2'b11;

  localparam logic [7:0] COIN_HALF = 8'd1;
  localparam logic [7:0] COIN_ONE  = 8'd2;

  localparam int PRICE_ENTRIES = 10;
  // Half-yuan prices: goods 0 = 1.5 yuan ... goods 9 = 6.0 yuan.
  localparam logic [7:0] PRICE_HALF [PRICE_ENTRIES] = '{
    8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd10, 8'd11, 8'd12
  };

  function automatic logic [7:0] price_of(input logic [3:0] idx);
    logic [7:0] p;
    p = 8'd0;
    for (int i = 0; i < PRICE_ENTRIES; i++) begin
      if (idx == 4'(i)) p = PRICE_HALF[i];
    end
    return p;
  endfunction

endpackage

// File: rtl/vend_hold_timer.sv
// Loadable down-counter holding the VEND and CHANGE screens; zero marks terminal count.
module vend_hold_timer
  import vend_pkg::*;
#(
  parameter int WIDTH = 26
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             count,
  output logic             zero
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (count && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/vend_ctrl.sv
// Vending transaction controller: tracks credit in half-yuan units and drives the display bundle.
// state  | meaning
// IDLE   | no credit, goods selection only
// PAY    | credit held, awaiting more coins / confirm / cancel
// VEND   | goods released, holding vend screen
// CHANGE | returning credit, holding change screen
module vend_ctrl
  import vend_pkg::*;
#(
  parameter int NUM_GOODS   = 10,
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int MAX_CREDIT  = 199
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       key_sel,
  input  logic       key_coin_half,
  input  logic       key_coin_one,
  input  logic       key_confirm,
  input  logic       key_cancel,
  output logic [3:0] goods_index,
  output logic [6:0] money,
  output logic       point_flag,
  output logic [1:0] money_flag,
  output logic       dispense,
  output logic       change_valid,
  output logic       coin_reject
);

  localparam int TW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  state_e     state_q, state_d;
  logic [7:0] credit_q, credit_d;
  logic [3:0] goods_q, goods_d;
  logic [1:0] flag_q, flag_d;
  logic       dispense_q, dispense_d;
  logic       change_valid_q, change_valid_d;
  logic       reject_q, reject_d;

  logic       tmr_load, tmr_count, tmr_zero;
  logic [7:0] coin_val, price_half;
  logic [8:0] coin_sum;
  logic       coin_key, coin_ok;
  logic [3:0] goods_next;

  vend_hold_timer #(.WIDTH(TW)) u_hold_timer (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .load     (tmr_load),
    .load_val (TW'(HOLD_CYCLES - 1)),
    .count    (tmr_count),
    .zero     (tmr_zero)
  );

  always_comb begin
    coin_key   = key_coin_one | key_coin_half;
    coin_val   = key_coin_one ? COIN_ONE : (key_coin_half ? COIN_HALF : 8'd0);
    coin_sum   = {1'b0, credit_q} + {1'b0, coin_val};
    coin_ok    = (coin_sum <= 9'(MAX_CREDIT));
    price_half = price_of(goods_q);
    goods_next = (goods_q == 4'(NUM_GOODS - 1)) ? 4'd0 : goods_q + 4'd1;
  end

  always_comb begin
    state_d    = state_q;
    credit_d   = credit_q;
    goods_d    = goods_q;
    flag_d     = flag_q;
    dispense_d = 1'b0;
    reject_d   = 1'b0;
    tmr_load   = 1'b0;
    tmr_count  = (state_q == VEND) || (state_q == CHANGE);

    unique case (state_q)
      IDLE: begin
        // confirm/cancel win priority but do nothing here, so lower keys are dropped too
        if (!key_cancel && !key_confirm) begin
          if (coin_key) begin
            if (coin_ok) begin
              credit_d = coin_sum[7:0];
              state_d  = PAY;
            end else begin
              reject_d = 1'b1;
            end
          end else if (key_sel) begin
            goods_d = goods_next;
          end
        end
      end
      PAY: begin
        if (key_cancel) begin
          state_d  = CHANGE;
          flag_d   = FLAG_CHANGE;
          tmr_load = 1'b1;
        end else if (key_confirm) begin
          if (credit_q >= price_half) begin
            state_d    = VEND;
            credit_d   = credit_q - price_half;
            flag_d     = FLAG_VEND;
            dispense_d = 1'b1;
            tmr_load   = 1'b1;
          end else begin
            flag_d = FLAG_SHORT;
          end
        end else if (coin_key) begin
          if (coin_ok) begin
            credit_d = coin_sum[7:0];
            flag_d   = FLAG_NORMAL;
          end else begin
            reject_d = 1'b1;
          end
        end else if (key_sel) begin
          goods_d = goods_next;
          flag_d  = FLAG_NORMAL;
        end
      end
      VEND: begin
        if (tmr_zero) begin
          if (credit_q != 8'd0) begin
            state_d  = CHANGE;
            flag_d   = FLAG_CHANGE;
            tmr_load = 1'b1;
          end else begin
            state_d = IDLE;
            flag_d  = FLAG_NORMAL;
          end
        end
      end
      CHANGE: begin
        if (tmr_zero) begin
          state_d  = IDLE;
          credit_d = 8'd0;
          flag_d   = FLAG_NORMAL;
        end
      end
      default: state_d = IDLE;
    endcase

    change_valid_d = (state_d == CHANGE);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q        <= IDLE;
      credit_q       <= 8'd0;
      goods_q        <= 4'd0;
      flag_q         <= FLAG_NORMAL;
      dispense_q     <= 1'b0;
      change_valid_q <= 1'b0;
      reject_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      credit_q       <= credit_d;
      goods_q        <= goods_d;
      flag_q         <= flag_d;
      dispense_q     <= dispense_d;
      change_valid_q <= change_valid_d;
      reject_q       <= reject_d;
    end
  end

  // In CHANGE the held credit is the refund, so the display always shows credit.
  assign goods_index  = goods_q;
  assign money        = credit_q[7:1];
  assign point_flag   = credit_q[0];
  assign money_flag   = flag_q;
  assign dispense     = dispense_q;
  assign change_valid = change_valid_q;
  assign coin_reject  = reject_q;

endmodule

// File: tb/tb_vend_ctrl.sv
// Directed bench for vend_ctrl with a 4-cycle hold; expected values are hand-computed.
module tb_vend_ctrl;

  localparam logic [4:0] K_NONE = 5'b00000;
  localparam logic [4:0] K_SEL  = 5'b00001;
  localparam logic [4:0] K_HALF = 5'b00010;
  localparam logic [4:0] K_ONE  = 5'b00100;
  localparam logic [4:0] K_CONF = 5'b01000;
  localparam logic [4:0] K_CAN  = 5'b10000;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic       key_sel, key_coin_half, key_coin_one, key_confirm, key_cancel;
  logic [3:0] goods_index;
  logic [6:0] money;
  logic       point_flag;
  logic [1:0] money_flag;
  logic       dispense, change_valid, coin_reject;

  int n_total = 0;
  int n_pass  = 0;

  vend_ctrl #(.NUM_GOODS(10), .HOLD_CYCLES(4), .MAX_CREDIT(199)) dut (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .key_sel       (key_sel),
    .key_coin_half (key_coin_half),
    .key_coin_one  (key_coin_one),
    .key_confirm   (key_confirm),
    .key_cancel    (key_cancel),
    .goods_index   (goods_index),
    .money         (money),
    .point_flag    (point_flag),
    .money_flag    (money_flag),
    .dispense      (dispense),
    .change_valid  (change_valid),
    .coin_reject   (coin_reject)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_disp(input string tag, input int m, input int p, input int f);
    chk({tag, ".money"}, 32'(money), 32'(m));
    chk({tag, ".point"}, 32'(point_flag), 32'(p));
    chk({tag, ".flag"}, 32'(money_flag), 32'(f));
  endtask

  // Key applied for one cycle; outputs sampled 1 time unit after the sampling edge.
  task automatic press(input logic [4:0] k);
    {key_cancel, key_confirm, key_coin_one, key_coin_half, key_sel} = k;
    @(posedge sys_clk);
    #1;
    {key_cancel, key_confirm, key_coin_one, key_coin_half, key_sel} = K_NONE;
  endtask

  initial begin
    sys_rst = 1'b1;
    {key_cancel, key_confirm, key_coin_one, key_coin_half, key_sel} = K_NONE;
    repeat (2) @(posedge sys_clk);
    #1;
    chk("rst.goods", 32'(goods_index), 0);
    chk_disp("rst", 0, 0, 0);
    chk("rst.dispense", 32'(dispense), 0);
    chk("rst.change_valid", 32'(change_valid), 0);
    chk("rst.coin_reject", 32'(coin_reject), 0);
    sys_rst = 1'b0;

    // Selection wraps 9 -> 0
    for (int i = 1; i <= 11; i++) begin
      press(K_SEL);
      chk("sel.goods", 32'(goods_index), 32'(i % 10));
      chk_disp("sel", 0, 0, 0);
    end

    // Goods 2 (price 5 halves), exact payment
    press(K_SEL);
    chk("g2.goods", 32'(goods_index), 2);
    press(K_ONE);
    chk_disp("g2.one1", 1, 0, 0);
    press(K_ONE);
    press(K_HALF);
    chk_disp("g2.paid", 2, 1, 0);
    press(K_CONF);
    chk("g2.dispense", 32'(dispense), 1);
    chk_disp("g2.vend", 0, 0, 1);
    for (int k = 0; k < 3; k++) begin
      press((k == 1) ? K_SEL : K_NONE);
      chk("g2.hold.flag", 32'(money_flag), 1);
      chk("g2.hold.dispense", 32'(dispense), 0);
      chk("g2.hold.goods", 32'(goods_index), 2);
    end
    press(K_NONE);
    chk_disp("g2.idle", 0, 0, 0);
    chk("g2.idle.cv", 32'(change_valid), 0);

    // Goods 0 (price 3 halves): short, then overpay by 0.5
    for (int i = 0; i < 8; i++) press(K_SEL);
    chk("g0.goods", 32'(goods_index), 0);
    press(K_ONE);
    press(K_CONF);
    chk_disp("g0.short", 1, 0, 2);
    chk("g0.short.dispense", 32'(dispense), 0);
    press(K_ONE);
    chk_disp("g0.coin", 2, 0, 0);
    press(K_CONF);
    chk("g0.dispense", 32'(dispense), 1);
    chk_disp("g0.vend", 0, 1, 1);
    for (int k = 0; k < 3; k++) begin
      press(K_NONE);
      chk("g0.vhold.flag", 32'(money_flag), 1);
    end
    press(K_NONE);
    chk_disp("g0.change", 0, 1, 3);
    chk("g0.change.cv", 32'(change_valid), 1);
    for (int k = 0; k < 3; k++) begin
      press(K_NONE);
      chk("g0.chold.cv", 32'(change_valid), 1);
      chk("g0.chold.flag", 32'(money_flag), 3);
    end
    press(K_NONE);
    chk_disp("g0.idle", 0, 0, 0);
    chk("g0.idle.cv", 32'(change_valid), 0);

    // Confirm in IDLE is ignored
    press(K_CONF);
    chk("idle.conf.dispense", 32'(dispense), 0);
    chk_disp("idle.conf", 0, 0, 0);

    // Cancel refunds 1.5
    press(K_HALF);
    press(K_HALF);
    press(K_HALF);
    chk_disp("can.credit", 1, 1, 0);
    press(K_CAN);
    chk_disp("can.change", 1, 1, 3);
    chk("can.cv", 32'(change_valid), 1);
    chk("can.dispense", 32'(dispense), 0);
    for (int k = 0; k < 3; k++) press(K_NONE);
    chk("can.hold.cv", 32'(change_valid), 1);
    press(K_NONE);
    chk_disp("can.idle", 0, 0, 0);
    chk("can.idle.cv", 32'(change_valid), 0);

    // Credit ceiling at 99.5
    for (int i = 0; i < 99; i++) press(K_ONE);
    chk_disp("ceil.99", 99, 0, 0);
    chk("ceil.99.reject", 32'(coin_reject), 0);
    press(K_HALF);
    chk_disp("ceil.99h", 99, 1, 0);
    chk("ceil.99h.reject", 32'(coin_reject), 0);
    press(K_HALF);
    chk("ceil.rej.half", 32'(coin_reject), 1);
    chk_disp("ceil.rej.half", 99, 1, 0);
    press(K_NONE);
    chk("ceil.rej.clear", 32'(coin_reject), 0);
    press(K_ONE);
    chk("ceil.rej.one", 32'(coin_reject), 1);
    chk_disp("ceil.rej.one", 99, 1, 0);

    // Cancel beats a same-cycle coin
    press(K_CAN | K_ONE);
    chk_disp("prio.change", 99, 1, 3);
    chk("prio.cv", 32'(change_valid), 1);
    chk("prio.reject", 32'(coin_reject), 0);
    for (int k = 0; k < 4; k++) press(K_NONE);
    chk_disp("prio.idle", 0, 0, 0);

    // Reset during VEND hold
    press(K_SEL);
    press(K_ONE);
    press(K_ONE);
    press(K_CONF);
    chk("rv.dispense", 32'(dispense), 1);
    chk("rv.goods", 32'(goods_index), 1);
    press(K_NONE);
    sys_rst = 1'b1;
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    chk("rv.goods.rst", 32'(goods_index), 0);
    chk_disp("rv.rst", 0, 0, 0);
    chk("rv.cv.rst", 32'(change_valid), 0);
    chk("rv.dispense.rst", 32'(dispense), 0);
    for (int k = 0; k < 5; k++) press(K_NONE);
    chk_disp("rv.after", 0, 0, 0);
    chk("rv.after.dispense", 32'(dispense), 0);
    chk("rv.after.cv", 32'(change_valid), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
